// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// bus response codes, reset PC and small decode helpers.
package ysyx_23060201_ifu_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_NEXT = 3'd4
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    // A fetch address is usable on the bus only when word aligned.
    function automatic logic pc_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Any response other than OKAY marks the fetched word as faulted.
    function automatic logic resp_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: issues one AR/R read per instruction, hands the
// result to the IDU over valid/ready, then waits for the EXU next PC.
// Only one instruction is in flight; all outputs come straight from flops.
module ysyx_23060201_ifu
    import ysyx_23060201_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dnpc_valid,
    input  logic [31:0]      dnpc,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic             inst_fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_e state_r;
    ifu_state_e next_state_s;

    logic [31:0]      pc_r;
    logic [31:0]      inst_r;
    logic             inst_fault_r;
    logic [CNT_W-1:0] fetch_cnt_r;
    logic             arvalid_r;
    logic             rready_r;
    logic             inst_valid_r;

    // Next-state selection; each state only reacts to its own handshake.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IFU_IDLE: next_state_s = IFU_REQ;
            IFU_REQ: begin
                if (arready) begin
                    next_state_s = IFU_WAIT;
                end else begin
                    next_state_s = IFU_REQ;
                end
            end
            IFU_WAIT: begin
                if (rvalid) begin
                    next_state_s = IFU_HOLD;
                end else begin
                    next_state_s = IFU_WAIT;
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    next_state_s = IFU_NEXT;
                end else begin
                    next_state_s = IFU_HOLD;
                end
            end
            IFU_NEXT: begin
                if (!dnpc_valid) begin
                    next_state_s = IFU_NEXT;
                end else if (pc_aligned(dnpc)) begin
                    next_state_s = IFU_REQ;
                end else begin
                    next_state_s = IFU_HOLD;
                end
            end
            default: next_state_s = IFU_IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IFU_IDLE;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            arvalid_r    <= (next_state_s == IFU_REQ);
            rready_r     <= (next_state_s == IFU_WAIT);
            inst_valid_r <= (next_state_s == IFU_HOLD);
        end
    end

    // Datapath: capture read data, count handoffs, load the next PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_fault_r <= 1'b0;
            fetch_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IFU_WAIT: begin
                    if (rvalid) begin
                        if (resp_ok(rresp)) begin
                            inst_r       <= rdata;
                            inst_fault_r <= 1'b0;
                        end else begin
                            inst_r       <= 32'h0000_0000;
                            inst_fault_r <= 1'b1;
                        end
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt_r <= fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                IFU_NEXT: begin
                    if (dnpc_valid) begin
                        pc_r <= dnpc;
                        // Misaligned targets never reach the bus; report a fault.
                        if (!pc_aligned(dnpc)) begin
                            inst_r       <= 32'h0000_0000;
                            inst_fault_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign araddr     = pc_r;
    assign pc         = pc_r;
    assign arvalid    = arvalid_r;
    assign rready     = rready_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_fault = inst_fault_r;
    assign fetch_cnt  = fetch_cnt_r;

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Directed bench for the fetch unit. Stimulus tasks drive the bus, IDU and
// EXU sides on the falling edge and push the expected IDU handoffs into a
// queue; a monitor pops and compares whenever a handoff takes place.
module tb_ysyx_23060201_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dnpc_valid = 1'b0;
    logic [31:0] dnpc = 32'h0000_0000;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0000_0000;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    ysyx_23060201_ifu #(.RESET_PC(32'h8000_0000), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .dnpc_valid (dnpc_valid),
        .dnpc       (dnpc),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .inst_fault (inst_fault),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every IDU handoff must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_handoff", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_inst", inst, e.inst);
                    check("sb_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                    check("sb_cnt", fetch_cnt, e.cnt);
                end
            end
        end
    end

    // One bus read starting in REQ, ending with the FSM in HOLD.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                         input logic [1:0] resp, input int ar_stall, input int r_stall);
        for (int i = 0; i < ar_stall; i++) begin
            arready = 1'b0;
            check("ar_stall_arvalid", {31'd0, arvalid}, 32'd1);
            check("ar_stall_araddr", araddr, exp_addr);
            step();
        end
        check("arvalid", {31'd0, arvalid}, 32'd1);
        check("araddr", araddr, exp_addr);
        check("req_rready", {31'd0, rready}, 32'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("wait_arvalid", {31'd0, arvalid}, 32'd0);
        check("wait_rready", {31'd0, rready}, 32'd1);
        for (int i = 0; i < r_stall; i++) begin
            dnpc_valid = 1'b1;
            dnpc       = 32'hdead_bee0;
            check("r_stall_inst_valid", {31'd0, inst_valid}, 32'd0);
            step();
            check("r_stall_rready", {31'd0, rready}, 32'd1);
            check("r_stall_pc", pc, exp_addr);
        end
        dnpc_valid = 1'b0;
        rvalid     = 1'b1;
        rdata      = data;
        rresp      = resp;
        step();
        rvalid = 1'b0;
        rdata  = 32'h0000_0000;
        rresp  = 2'b00;
        check("hold_rready", {31'd0, rready}, 32'd0);
        check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("hold_pc", pc, exp_addr);
    endtask

    // IDU takes the instruction after 'stall' refused cycles; FSM ends in NEXT.
    task automatic accept(input int stall, input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                          input logic exp_fault, input logic [31:0] exp_cnt);
        exp_t e;
        e.pc    = exp_pc;
        e.inst  = exp_inst;
        e.fault = exp_fault;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0;
            dnpc_valid = 1'b1;
            dnpc       = 32'h1234_5670;
            rvalid     = 1'b1;
            rdata      = 32'hffff_ffff;
            check("idu_stall_valid", {31'd0, inst_valid}, 32'd1);
            check("idu_stall_rready", {31'd0, rready}, 32'd0);
            check("idu_stall_cnt", fetch_cnt, exp_cnt);
            step();
            check("idu_stall_pc", pc, exp_pc);
            check("idu_stall_inst", inst, exp_inst);
        end
        dnpc_valid = 1'b0;
        rvalid     = 1'b0;
        rdata      = 32'h0000_0000;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("next_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("next_arvalid", {31'd0, arvalid}, 32'd0);
        check("next_cnt", fetch_cnt, exp_cnt + 32'd1);
    endtask

    // EXU supplies the next PC after 'stall' idle cycles in NEXT.
    task automatic next_pc(input logic [31:0] val, input int stall);
        for (int i = 0; i < stall; i++) begin
            check("dnpc_wait_arvalid", {31'd0, arvalid}, 32'd0);
            check("dnpc_wait_valid", {31'd0, inst_valid}, 32'd0);
            step();
        end
        dnpc_valid = 1'b1;
        dnpc       = val;
        step();
        dnpc_valid = 1'b0;
        check("dnpc_pc", pc, val);
    endtask

    initial begin
        step();
        step();
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0000_0000);
        check("rst_fault", {31'd0, inst_fault}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        rst = 1'b1;
        check("idle_arvalid", {31'd0, arvalid}, 32'd0);
        step();

        // Zero-wait loop of two instructions.
        fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0);
        accept(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 32'd0);
        next_pc(32'h8000_0004, 0);
        fetch(32'h8000_0004, 32'h0010_0073, 2'b00, 0, 0);
        accept(0, 32'h8000_0004, 32'h0010_0073, 1'b0, 32'd1);
        next_pc(32'h8000_0008, 0);

        // Backpressure on every handshake, with ignored dnpc/rvalid pulses.
        fetch(32'h8000_0008, 32'h1234_5678, 2'b00, 3, 5);
        accept(4, 32'h8000_0008, 32'h1234_5678, 1'b0, 32'd2);
        next_pc(32'h8000_0010, 2);

        // Error response.
        fetch(32'h8000_0010, 32'hcafe_babe, 2'b10, 0, 0);
        check("err_inst", inst, 32'h0000_0000);
        check("err_fault", {31'd0, inst_fault}, 32'd1);
        accept(0, 32'h8000_0010, 32'h0000_0000, 1'b1, 32'd3);

        // Misaligned next PC skips the bus.
        next_pc(32'h8000_0022, 0);
        check("mis_arvalid", {31'd0, arvalid}, 32'd0);
        check("mis_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("mis_fault", {31'd0, inst_fault}, 32'd1);
        accept(1, 32'h8000_0022, 32'h0000_0000, 1'b1, 32'd4);
        next_pc(32'h8000_0024, 0);
        fetch(32'h8000_0024, 32'h0000_0013, 2'b00, 0, 1);
        accept(0, 32'h8000_0024, 32'h0000_0013, 1'b0, 32'd5);
        next_pc(32'h8000_0028, 0);

        // Asynchronous reset while waiting for read data.
        check("pre_rst_araddr", araddr, 32'h8000_0028);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("pre_rst_rready", {31'd0, rready}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_arvalid", {31'd0, arvalid}, 32'd0);
        check("async_rready", {31'd0, rready}, 32'd0);
        check("async_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_pc", pc, 32'h8000_0000);
        check("async_cnt", fetch_cnt, 32'd0);
        step();
        rst = 1'b1;
        step();
        fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0);
        accept(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 32'd0);

        step();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
